// File: rtl/secjmp_pkg.sv
// Shared constants and types for the jump-target filter.
package secjmp_pkg;

   // Default opcodes classed as jumps
   localparam int unsigned JMP_OP0_DEF = 32'd2;
   localparam int unsigned JMP_OP1_DEF = 32'd3;

   // Violation handling mode
   localparam logic MODE_SQUASH = 1'b0;   // emit an all-zero word
   localparam logic MODE_DROP   = 1'b1;   // consume the word, emit nothing

   // Violation counter
   localparam int unsigned CNT_W   = 32'd16;
   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   // Filter FSM
   typedef enum logic {
      ST_PASS   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

endpackage

// File: rtl/secjmp_check.sv
// Combinational classifier: decides whether an opcode is a jump, and whether
// that jump's target falls outside the legal window (or is zero).
module secjmp_check #(
   parameter int unsigned OP_W    = 32'd6,
   parameter int unsigned TGT_W   = 32'd26,
   parameter int unsigned JMP_OP0 = 32'd2,
   parameter int unsigned JMP_OP1 = 32'd3
) (
   input  logic [OP_W-1:0]  op_i,
   input  logic [TGT_W-1:0] tgt_i,
   input  logic [TGT_W-1:0] tgt_lo_i,
   input  logic [TGT_W-1:0] tgt_hi_i,
   output logic             is_jump_o,
   output logic             violation_o
);

   // Classify the word; non-jumps can never violate
   always_comb begin
      is_jump_o   = (op_i == OP_W'(JMP_OP0)) || (op_i == OP_W'(JMP_OP1));
      violation_o = 1'b0;
      if (is_jump_o) begin
         violation_o = (tgt_i == '0) || (tgt_i < tgt_lo_i) || (tgt_i > tgt_hi_i);
      end else begin
         violation_o = 1'b0;
      end
   end

endmodule

// File: rtl/secjmp_filter.sv
// Streaming jump-target filter. Words pass through a single output register
// with one cycle of latency. Jumps whose target is outside the legal window
// are squashed to zero or dropped, counted, and after LOCK_THRESH consecutive
// violations the filter locks until explicitly unlocked.
module secjmp_filter
   import secjmp_pkg::*;
#(
   parameter int unsigned DATA_W      = 32'd64,
   parameter int unsigned OP_LSB      = 32'd26,
   parameter int unsigned OP_W        = 32'd6,
   parameter int unsigned TGT_W       = 32'd26,
   parameter int unsigned JMP_OP0     = JMP_OP0_DEF,
   parameter int unsigned JMP_OP1     = JMP_OP1_DEF,
   parameter int unsigned LOCK_THRESH = 32'd4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mode,
   input  logic [TGT_W-1:0]  tgt_lo,
   input  logic [TGT_W-1:0]  tgt_hi,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              viol,
   output logic [CNT_W-1:0]  viol_cnt,
   input  logic              cnt_clr,
   output logic              locked,
   input  logic              unlock
);

   localparam int unsigned   CW       = $clog2(LOCK_THRESH + 32'd1);
   localparam logic [CW-1:0] THRESH_C = CW'(LOCK_THRESH);

   state_t              state_q;
   logic [CW-1:0]       consec_q;
   logic                locked_q;
   logic                out_valid_q, out_valid_d;
   logic [DATA_W-1:0]   out_data_q,  out_data_d;
   logic                viol_q,      viol_d;
   logic [CNT_W-1:0]    viol_cnt_q,  viol_cnt_d;

   logic                accept;
   logic                chk_jump;
   logic                chk_viol;
   logic                pass_viol;
   logic                word_viol;
   logic                emit;

   secjmp_check #(
      .OP_W    (OP_W),
      .TGT_W   (TGT_W),
      .JMP_OP0 (JMP_OP0),
      .JMP_OP1 (JMP_OP1)
   ) u_check (
      .op_i        (in_data[OP_LSB +: OP_W]),
      .tgt_i       (in_data[TGT_W-1:0]),
      .tgt_lo_i    (tgt_lo),
      .tgt_hi_i    (tgt_hi),
      .is_jump_o   (chk_jump),
      .violation_o (chk_viol)
   );

   // Full-throughput handshake: a new word may enter whenever the output slot
   // is empty or is being drained this cycle.
   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // Judge the word: in LOCKED every word is treated as a violation; the
   // mode is sampled only here, so a held output is never re-judged.
   always_comb begin
      pass_viol = chk_jump && chk_viol;
      word_viol = (state_q == ST_LOCKED) || pass_viol;
      emit      = accept && !(word_viol && (mode == MODE_DROP));
   end

   // Next-state for the output register, violation pulse and counter
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (emit) begin
         out_valid_d = 1'b1;
         out_data_d  = word_viol ? {DATA_W{1'b0}} : in_data;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end

      viol_d = accept && word_viol;

      // Clear wins over a same-cycle increment; LOCKED words are not counted
      viol_cnt_d = viol_cnt_q;
      if (cnt_clr) begin
         viol_cnt_d = {CNT_W{1'b0}};
      end else if (accept && pass_viol && (state_q == ST_PASS) &&
                   (viol_cnt_q != CNT_MAX)) begin
         viol_cnt_d = viol_cnt_q + 16'd1;
      end else begin
         viol_cnt_d = viol_cnt_q;
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= {DATA_W{1'b0}};
         viol_q      <= 1'b0;
         viol_cnt_q  <= {CNT_W{1'b0}};
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         viol_q      <= viol_d;
         viol_cnt_q  <= viol_cnt_d;
      end
   end

   // PASS/LOCKED FSM with the consecutive-violation counter and locked flag.
   // A word accepted together with unlock is judged in LOCKED (above); the
   // transition only affects the following word.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_PASS;
         consec_q <= {CW{1'b0}};
         locked_q <= 1'b0;
      end else begin
         case (state_q)
            ST_PASS: begin
               if (accept && pass_viol) begin
                  consec_q <= consec_q + CW'(1);
                  if ((consec_q + CW'(1)) == THRESH_C) begin
                     state_q  <= ST_LOCKED;
                     locked_q <= 1'b1;
                  end
               end else if (accept) begin
                  consec_q <= {CW{1'b0}};
               end
            end
            ST_LOCKED: begin
               if (unlock) begin
                  state_q  <= ST_PASS;
                  consec_q <= {CW{1'b0}};
                  locked_q <= 1'b0;
               end
            end
            default: begin
               state_q  <= ST_PASS;
               consec_q <= {CW{1'b0}};
               locked_q <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign viol      = viol_q;
   assign viol_cnt  = viol_cnt_q;
   assign locked    = locked_q;

endmodule
